// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I fetch path.
package riscv_pkg;

  // Fetch controller states; 3-bit encoding leaves room for a later pipelined stage.
  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_HALTED = 3'd4,
    ST_ERROR  = 3'd5
  } fetch_state_t;

  // Every RV32I instruction is one 32-bit word.
  localparam int         INSTR_BYTES = 4;
  // Address bits that must be zero for a word-aligned fetch target.
  localparam logic [1:0] ALIGN_MASK  = 2'b11;

  // True when the two low address bits would make a fetch target non-word-aligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
    return (addr_lsbs & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: sequential (pc + 4) or taken branch (pc + imm_op),
// plus a flag for a non-word-aligned result. Purely combinational so a
// pipelined fetch stage can reuse it unchanged.
module pc_next_calc
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] imm_op,
  input  logic                  pcsrc,
  output logic [DATA_WIDTH-1:0] next_pc,
  output logic                  misalign
);

  logic [DATA_WIDTH-1:0] seq_pc;
  logic [DATA_WIDTH-1:0] branch_pc;

  // Both candidates wrap modulo 2^DATA_WIDTH; overflow is not an error.
  always_comb begin
    seq_pc    = pc + DATA_WIDTH'(INSTR_BYTES);
    branch_pc = pc + imm_op;
    next_pc   = pcsrc ? branch_pc : seq_pc;
    misalign  = is_misaligned(next_pc[1:0]);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch controller. Owns the PC, issues one memory
// request per instruction, holds the returned word in an instruction register
// until decode accepts it, then applies the branch decision and moves on.
module fetch_sequencer
  import riscv_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] pc,
  input  logic                  pcsrc,
  input  logic [DATA_WIDTH-1:0] imm_op,
  input  logic                  halt,
  output logic                  halted,
  output logic                  err_misalign,
  output logic [CNT_WIDTH-1:0]  retired_count
);

  fetch_state_t          state;
  fetch_state_t          state_nxt;
  logic                  accept;
  logic                  capture;
  logic [DATA_WIDTH-1:0] next_pc;
  logic                  next_misalign;

  // The fetch address is always the current PC; imem_req qualifies it.
  assign imem_addr = pc;

  pc_next_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pc_next_calc (
    .pc      (pc),
    .imm_op  (imm_op),
    .pcsrc   (pcsrc),
    .next_pc (next_pc),
    .misalign(next_misalign)
  );

  // Next-state decision; accept and capture are only meaningful in their own states.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    accept    = (state == ST_ISSUE) && instr_ready;
    capture   = (state == ST_WAIT) && imem_rvalid;
    case (state)
      ST_RESET:  state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_WAIT;
      ST_WAIT:   if (imem_rvalid) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (accept) begin
          if (next_misalign) state_nxt = ST_ERROR;
          else if (halt)     state_nxt = ST_HALTED;
          else               state_nxt = ST_FETCH;
        end
      end
      ST_HALTED: if (!halt) state_nxt = ST_FETCH;
      ST_ERROR:  state_nxt = ST_ERROR;
      default:   state_nxt = ST_ERROR;
    endcase
  end

  // All architectural state and the registered handshake outputs, updated together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_RESET;
      pc            <= RESET_PC;
      // NOTE: instr is a single datapath register visible on a port, so it is reset
      // to a known zero; a storage array would be left unreset instead.
      instr         <= '0;
      imem_req      <= 1'b0;
      instr_valid   <= 1'b0;
      halted        <= 1'b0;
      err_misalign  <= 1'b0;
      retired_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state       <= state_nxt;
      imem_req    <= (state_nxt == ST_FETCH);
      instr_valid <= (state_nxt == ST_ISSUE);
      halted      <= (state_nxt == ST_HALTED);
      if (capture) begin
        instr <= imem_rdata;
      end
      if (accept) begin
        pc            <= next_pc;
        retired_count <= retired_count + CNT_WIDTH'(1);
        if (next_misalign) begin
          err_misalign <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a behavioural memory/decode model
// tracks the expected PC, retired count, halt and error status per instruction.
module tb_fetch_sequencer;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [DW-1:0] imem_addr;
  logic          imem_rvalid;
  logic [DW-1:0] imem_rdata;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr;
  logic [DW-1:0] pc;
  logic          pcsrc;
  logic [DW-1:0] imm_op;
  logic          halt;
  logic          halted;
  logic          err_misalign;
  logic [CW-1:0] retired_count;

  fetch_sequencer #(
    .DATA_WIDTH(DW),
    .RESET_PC  (32'h0000_0000),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .pc           (pc),
    .pcsrc        (pcsrc),
    .imm_op       (imm_op),
    .halt         (halt),
    .halted       (halted),
    .err_misalign (err_misalign),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [DW-1:0] m_pc;
  int            m_cnt;
  bit            m_err;
  bit            m_halted;
  bit            aborted = 1'b0;
  int unsigned   last_req_cyc;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    pcsrc = 1'b0; imm_op = '0; halt = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_pc = 32'h0; m_cnt = 0; m_err = 1'b0; m_halted = 1'b0;
  endtask

  // One full instruction: wait for request, respond after mem_dly cycles,
  // hold decode off for rdy_dly cycles, then accept with the given branch/halt.
  task automatic run_instr(input bit br, input logic [DW-1:0] imm, input bit hlt,
                           input int mem_dly, input int rdy_dly, input bit spurious);
    logic [DW-1:0] word;
    logic [DW-1:0] exp_pc;
    logic [DW-1:0] nxt;
    int k;
    if (aborted) return;
    k = 0;
    while (imem_req !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (imem_req !== 1'b1) begin
      fails++;
      $display("FAIL req_timeout: imem_req=%b after %0d cycles, required 1", imem_req, k);
      aborted = 1'b1;
      return;
    end
    last_req_cyc = cyc;
    tests++;
    if (imem_addr !== m_pc) begin
      fails++;
      $display("FAIL imem_addr: got %h required %h", imem_addr, m_pc);
    end
    exp_pc = m_pc;
    word   = $urandom;
    for (int i = 1; i <= mem_dly; i++) begin
      @(negedge clk);
      tests++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        fails++;
        $display("FAIL wait_quiet: req=%b valid=%b required 0/0", imem_req, instr_valid);
      end
      halt = 1'($urandom_range(0, 1));
      if (i == mem_dly) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word;
      end
    end
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    tests++;
    if (instr_valid !== 1'b1 || instr !== word || pc !== exp_pc) begin
      fails++;
      $display("FAIL issue: valid=%b instr=%h pc=%h required 1 %h %h",
               instr_valid, instr, pc, word, exp_pc);
    end
    for (int i = 0; i < rdy_dly; i++) begin
      instr_ready = 1'b0;
      pcsrc  = 1'($urandom_range(0, 1));
      imm_op = $urandom;
      halt   = 1'($urandom_range(0, 1));
      if (spurious) begin
        imem_rvalid = 1'b1;
        imem_rdata  = ~word;
      end
      @(negedge clk);
      imem_rvalid = 1'b0;
      tests++;
      if (instr_valid !== 1'b1 || instr !== word || pc !== exp_pc || imem_req !== 1'b0) begin
        fails++;
        $display("FAIL hold: valid=%b instr=%h pc=%h req=%b required 1 %h %h 0",
                 instr_valid, instr, pc, imem_req, word, exp_pc);
      end
    end
    instr_ready = 1'b1;
    pcsrc  = br;
    imm_op = imm;
    halt   = hlt;
    @(negedge clk);
    instr_ready = 1'b0;
    pcsrc  = 1'($urandom_range(0, 1));
    imm_op = $urandom;
    // Model: the spec's rule for the next PC and status after an accept.
    nxt   = br ? exp_pc + imm : exp_pc + 32'd4;
    m_pc  = nxt;
    m_cnt = m_cnt + 1;
    if (nxt[1:0] != 2'b00) m_err = 1'b1;
    else if (hlt)          m_halted = 1'b1;
    tests++;
    if (pc !== m_pc) begin
      fails++;
      $display("FAIL next_pc: got %h required %h", pc, m_pc);
    end
    tests++;
    if (retired_count !== CW'(m_cnt)) begin
      fails++;
      $display("FAIL retired_count: got %0d required %0d", retired_count, CW'(m_cnt));
    end
    tests++;
    if (err_misalign !== m_err || halted !== m_halted || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL status: err=%b halted=%b valid=%b required %b %b 0",
               err_misalign, halted, instr_valid, m_err, m_halted);
    end
    tests++;
    if (imem_req !== (!m_err && !m_halted)) begin
      fails++;
      $display("FAIL accept_latency: imem_req=%b required %b", imem_req, !m_err && !m_halted);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    run_instr(1'b0, '0, 1'b0, 1, 0, 1'b0);
    run_instr(1'b0, '0, 1'b0, 2, 1, 1'b0);
    if (aborted) return;
    @(negedge clk);   // request for 0x8 issued, now waiting on memory
    #2 rst = 1'b1;
    #1;
    tests++;
    if (pc !== 32'h0 || imem_addr !== 32'h0 || instr !== 32'h0 || imem_req !== 1'b0 ||
        instr_valid !== 1'b0 || halted !== 1'b0 || err_misalign !== 1'b0 ||
        retired_count !== '0) begin
      fails++;
      $display("FAIL async_reset: pc=%h instr=%h req=%b valid=%b halted=%b err=%b cnt=%0d required all zero",
               pc, instr, imem_req, instr_valid, halted, err_misalign, retired_count);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pc = 32'h0; m_cnt = 0; m_err = 1'b0; m_halted = 1'b0;
    @(negedge clk);
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL first_req: req=%b addr=%h required 1 00000000", imem_req, imem_addr);
    end
    // Late response from the aborted fetch lands while in FETCH.
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    @(negedge clk);
    tests++;
    if (instr_valid !== 1'b0 || instr !== 32'h0) begin
      fails++;
      $display("FAIL late_rvalid: valid=%b instr=%h required 0 00000000", instr_valid, instr);
    end
  endtask

  task automatic test_sequential();
    int unsigned req_at[4];
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      run_instr(1'b0, '0, 1'b0, 1, 0, 1'b0);
      req_at[i] = last_req_cyc;
    end
    for (int i = 1; i < 4; i++) begin
      tests++;
      if (req_at[i] - req_at[i-1] != 3) begin
        fails++;
        $display("FAIL req_period: %0d cycles between requests, required 3",
                 req_at[i] - req_at[i-1]);
      end
    end
    tests++;
    if (retired_count !== 4'd4 || pc !== 32'h10) begin
      fails++;
      $display("FAIL seq_end: cnt=%0d pc=%h required 4 00000010", retired_count, pc);
    end
  endtask

  task automatic test_branch();
    // Starts at pc=0x10 from the sequential run.
    run_instr(1'b1, 32'hFFFF_FFF8, 1'b0, 1, 0, 1'b0);
    tests++;
    if (imem_addr !== 32'h08) begin
      fails++;
      $display("FAIL branch_back: addr=%h required 00000008", imem_addr);
    end
    run_instr(1'b1, 32'h0000_0008, 1'b0, 1, 0, 1'b0);
    run_instr(1'b1, 32'h0000_0020, 1'b0, 1, 0, 1'b0);
    tests++;
    if (imem_addr !== 32'h30) begin
      fails++;
      $display("FAIL branch_fwd: addr=%h required 00000030", imem_addr);
    end
    run_instr(1'b1, 32'hFFFF_FFE0, 1'b0, 1, 0, 1'b0);
    run_instr(1'b0, 32'h0000_0020, 1'b0, 1, 0, 1'b0);
    tests++;
    if (imem_addr !== 32'h14) begin
      fails++;
      $display("FAIL not_taken: addr=%h required 00000014", imem_addr);
    end
  endtask

  task automatic test_backpressure();
    run_instr(1'b0, '0, 1'b0, 5, 4, 1'b1);
    run_instr(1'b1, 32'h0000_0100, 1'b0, 3, 2, 1'b1);
  endtask

  task automatic test_halt();
    apply_reset();
    run_instr(1'b0, '0, 1'b0, 1, 0, 1'b0);
    run_instr(1'b0, '0, 1'b0, 1, 0, 1'b0);
    run_instr(1'b0, '0, 1'b1, 1, 0, 1'b0);
    if (aborted) return;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (halted !== 1'b1 || imem_req !== 1'b0) begin
        fails++;
        $display("FAIL halted_idle: halted=%b req=%b required 1 0", halted, imem_req);
      end
    end
    halt = 1'b0;
    m_halted = 1'b0;
    @(negedge clk);
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0C || halted !== 1'b0) begin
      fails++;
      $display("FAIL resume: req=%b addr=%h halted=%b required 1 0000000c 0",
               imem_req, imem_addr, halted);
    end
    run_instr(1'b0, '0, 1'b0, 2, 1, 1'b0);
  endtask

  task automatic test_misalign();
    apply_reset();
    run_instr(1'b0, '0, 1'b0, 1, 0, 1'b0);
    run_instr(1'b1, 32'h0000_0002, 1'b0, 1, 0, 1'b0);
    if (aborted) return;
    tests++;
    if (err_misalign !== 1'b1 || pc !== 32'h6) begin
      fails++;
      $display("FAIL misalign: err=%b pc=%h required 1 00000006", err_misalign, pc);
    end
    for (int i = 0; i < 10; i++) begin
      imem_rvalid = 1'($urandom_range(0, 1));
      instr_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      tests++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || err_misalign !== 1'b1 || pc !== 32'h6) begin
        fails++;
        $display("FAIL error_stuck: req=%b valid=%b err=%b pc=%h required 0 0 1 00000006",
                 imem_req, instr_valid, err_misalign, pc);
      end
    end
    apply_reset();
    tests++;
    if (err_misalign !== 1'b0 || pc !== 32'h0) begin
      fails++;
      $display("FAIL error_clear: err=%b pc=%h required 0 00000000", err_misalign, pc);
    end
  endtask

  task automatic test_counter_wrap();
    apply_reset();
    for (int i = 0; i < 17; i++) run_instr(1'b0, '0, 1'b0, 1, 0, 1'b0);
    tests++;
    if (retired_count !== 4'd1) begin
      fails++;
      $display("FAIL counter_wrap: got %0d required 1", retired_count);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] imm;
    bit            hlt;
    apply_reset();
    for (int n = 0; n < 60; n++) begin
      imm = $urandom & 32'h0000_03FC;
      if ($urandom_range(0, 1) == 1) imm = -imm;
      hlt = ($urandom_range(0, 7) == 0);
      run_instr(1'($urandom_range(0, 1)), imm, hlt, $urandom_range(1, 4),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if (aborted) return;
      if (hlt) begin
        repeat ($urandom_range(1, 5)) begin
          @(negedge clk);
          tests++;
          if (halted !== 1'b1 || imem_req !== 1'b0) begin
            fails++;
            $display("FAIL rand_halt: halted=%b req=%b required 1 0", halted, imem_req);
          end
        end
        halt = 1'b0;
        m_halted = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    pcsrc = 1'b0; imm_op = '0; halt = 1'b0;
    test_reset();
    test_sequential();
    test_branch();
    test_backpressure();
    test_halt();
    test_misalign();
    test_counter_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
